// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: valid/ready request and response
// channels, programmable wait states, byte-enable stores and address error flagging.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUSY  | wait states counting down; access performed when count reaches zero
// RESP  | response presented until the CPU accepts it
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  accept;
  logic                  access;
  logic                  addr_err;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem [DEPTH];

  assign req_ready  = (state_q == IDLE) & rst;
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid & req_ready;
  assign access     = (state_q == BUSY) && (cnt_q == 4'd0);
  assign idx        = addr_q[DEPTH_LOG2+1:2];
  assign addr_err   = (addr_q[1:0] != 2'b00) || (|addr_q[31:DEPTH_LOG2+2]);
  assign mem_we     = access & we_q & ~addr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(WAIT_CYCLES);
        we_q    <= req_we;
        be_q    <= req_be;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state_q == BUSY) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          resp_rdata <= (we_q || addr_err) ? 32'd0 : mem[idx];
          resp_err   <= addr_err;
        end
      end
    end
  end

  // Storage is intentionally not reset; writes happen only on the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: vector table of loads/stores plus
// hand-written backpressure and reset corner cases.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a request from a negedge and return #1 after the accept edge.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges from the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) break;
    end
  endtask

  task automatic ack;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("idle_after_ack", {30'd0, req_ready, resp_valid}, 32'b10);
  endtask

  int lat;
  logic [31:0] held;

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'h5, 32'h10,       32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 32'h12,       32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b1, 4'hF, 32'h12,       32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 4'h0, 32'h10,       32'h0,        32'hDE22BE44, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 32'h1000,     32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 4'hF, 32'hFFC,      32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 4'hF, 32'hFFC,      32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 32'h10,       32'h77777777, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDE22BE44, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 32'h80000010, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 4'hF, 32'h20,       32'hCAFEF00D, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 4'hF, 32'h20,       32'h0,        32'hCAFEF00D, 1'b0};

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_be     = 4'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, resp_valid, resp_err, 29'd0}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      wait_resp(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, resp_err}, {31'd0, vecs[i].exp_err});
      ack();
    end

    // Backpressure: hold response for 5 cycles while a stray request pulses.
    issue(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(lat);
    chk("bp_latency", 32'(lat), 32'(W + 1));
    held = resp_rdata;
    chk("bp_rdata", held, 32'hDE22BE44);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 32'h10;
        req_wdata = 32'h0BADF00D;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk($sformatf("bp_hold%0d", c), {29'd0, resp_valid, req_ready, resp_err}, 32'b100);
      chk($sformatf("bp_rdata%0d", c), resp_rdata, 32'hDE22BE44);
    end
    ack();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_stray_txn", {30'd0, resp_valid, req_ready}, 32'b01);
    end
    issue(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(lat);
    chk("bp_mem_unchanged", resp_rdata, 32'hDE22BE44);
    ack();

    // Reset in the middle of BUSY on a store to 0x20.
    issue(1'b1, 4'hF, 32'h20, 32'h12345678);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy_outputs", {req_ready, resp_valid, resp_err, 29'd0}, 32'd0);
    chk("rst_busy_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 4'hF, 32'h20, 32'h0);
    wait_resp(lat);
    chk("rst_busy_latency", 32'(lat), 32'(W + 1));
    chk("rst_busy_mem_kept", resp_rdata, 32'hCAFEF00D);
    chk("rst_busy_err", {31'd0, resp_err}, 32'd0);

    // Reset while a response is pending drops it.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_resp_outputs", {req_ready, resp_valid, resp_err, 29'd0}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_resp_dropped", {30'd0, resp_valid, req_ready}, 32'b01);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
